// File: rtl/hour12_clock.sv
// 12-hour time-of-day counter with 1 Hz prescaler, BCD outputs and MODE/INC set-time FSM.
// Hour held in binary 0..11 (0 displays as 12); minutes/seconds held as BCD digit pairs.
module hour12_clock #(
   parameter int DIV = 50000000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       EN,
   input  logic       MODE,
   input  logic       INC,
   output logic [3:0] HR_T,
   output logic [3:0] HR_O,
   output logic [3:0] MIN_T,
   output logic [3:0] MIN_O,
   output logic [3:0] SEC_T,
   output logic [3:0] SEC_O,
   output logic       PM,
   output logic [1:0] STATE,
   output logic       DAY
);

   localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10
   } state_t;

   state_t          state, state_n;
   logic [3:0]      h, h_n;
   logic [3:0]      min_t, min_t_n, min_o, min_o_n;
   logic [3:0]      sec_t, sec_t_n, sec_o, sec_o_n;
   logic            pm, pm_n;
   logic            day, day_n;
   logic [PW-1:0]   presc, presc_n;
   logic            counting, tick;
   logic [8:0]      sec_inc, min_inc;

   // Returns {carry, tens, ones} for a 00..59 BCD pair advanced by one.
   function automatic logic [8:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
      logic [8:0] r;
      if (o == 4'd9) begin
         if (t == 4'd5) r = {1'b1, 4'd0, 4'd0};
         else           r = {1'b0, t + 4'd1, 4'd0};
      end else begin
         r = {1'b0, t, o + 4'd1};
      end
      return r;
   endfunction

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= RUN;
         h     <= '0;
         min_t <= '0;
         min_o <= '0;
         sec_t <= '0;
         sec_o <= '0;
         pm    <= 1'b0;
         day   <= 1'b0;
         presc <= '0;
      end else begin
         state <= state_n;
         h     <= h_n;
         min_t <= min_t_n;
         min_o <= min_o_n;
         sec_t <= sec_t_n;
         sec_o <= sec_o_n;
         pm    <= pm_n;
         day   <= day_n;
         presc <= presc_n;
      end
   end

   always_comb begin
      state_n  = state;
      h_n      = h;
      min_t_n  = min_t;
      min_o_n  = min_o;
      sec_t_n  = sec_t;
      sec_o_n  = sec_o;
      pm_n     = pm;
      day_n    = 1'b0;
      presc_n  = presc;
      counting = (state == RUN) && !EN;
      tick     = counting && (presc == PW'(DIV - 1));
      sec_inc  = bcd_inc(sec_t, sec_o);
      min_inc  = bcd_inc(min_t, min_o);

      if (counting) presc_n = tick ? '0 : presc + 1'b1;

      unique case (state)
         RUN: begin
            if (MODE) begin
               state_n = SET_HR;
               sec_t_n = '0;
               sec_o_n = '0;
               presc_n = '0;
            end else if (tick) begin
               {sec_t_n, sec_o_n} = sec_inc[7:0];
               if (sec_inc[8]) begin
                  {min_t_n, min_o_n} = min_inc[7:0];
                  if (min_inc[8]) begin
                     if (h == 4'd11) begin
                        h_n   = '0;
                        pm_n  = ~pm;
                        day_n = pm;
                     end else begin
                        h_n = h + 4'd1;
                     end
                  end
               end
            end
         end
         SET_HR: begin
            if (MODE) begin
               state_n = SET_MIN;
            end else if (INC) begin
               if (h == 4'd11) begin
                  h_n  = '0;
                  pm_n = ~pm;
               end else begin
                  h_n = h + 4'd1;
               end
            end
         end
         SET_MIN: begin
            if (MODE) begin
               state_n = RUN;
               sec_t_n = '0;
               sec_o_n = '0;
               presc_n = '0;
            end else if (INC) begin
               {min_t_n, min_o_n} = min_inc[7:0];
            end
         end
         default: state_n = RUN;
      endcase
   end

   always_comb begin
      HR_T = 4'd0;
      HR_O = h;
      if (h == 4'd0) begin
         HR_T = 4'd1;
         HR_O = 4'd2;
      end else if (h >= 4'd10) begin
         HR_T = 4'd1;
         HR_O = h - 4'd10;
      end
   end

   assign MIN_T = min_t;
   assign MIN_O = min_o;
   assign SEC_T = sec_t;
   assign SEC_O = sec_o;
   assign PM    = pm;
   assign STATE = state;
   assign DAY   = day;

endmodule

// File: tb/tb_hour12_clock.sv
// Self-checking bench for hour12_clock: directed scenarios with literal expectations plus
// randomized MODE/INC/EN/RST_N traffic compared every cycle against a time-of-day model.
module tb_hour12_clock;

   localparam int DIV = 2;

   logic       clk = 1'b0;
   logic       rst_n, en, mode, inc;
   logic [3:0] hr_t, hr_o, min_t, min_o, sec_t, sec_o;
   logic       pm, day;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   int day_seen = 0;

   hour12_clock #(.DIV(DIV)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .EN    (en),
      .MODE  (mode),
      .INC   (inc),
      .HR_T  (hr_t),
      .HR_O  (hr_o),
      .MIN_T (min_t),
      .MIN_O (min_o),
      .SEC_T (sec_t),
      .SEC_O (sec_o),
      .PM    (pm),
      .STATE (state),
      .DAY   (day)
   );

   always #5 clk = ~clk;

   // Model: time as seconds since 12:00:00 within the half-day, mode as 0/1/2, tick counter.
   int   m_t    = 0;
   int   m_mode = 0;
   int   m_cnt  = 0;
   logic m_pm   = 1'b0;
   logic m_day  = 1'b0;
   logic started = 1'b0;

   always @(posedge clk) begin
      logic tk;
      int   hh, mm, ss;
      m_day = 1'b0;
      if (!rst_n) begin
         m_t = 0; m_mode = 0; m_cnt = 0; m_pm = 1'b0;
      end else begin
         tk = 1'b0;
         if (m_mode == 0 && !en) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == DIV) begin tk = 1'b1; m_cnt = 0; end
         end
         hh = m_t / 3600; mm = (m_t / 60) % 60; ss = m_t % 60;
         if (mode) begin
            if (m_mode != 1) begin m_t = m_t - ss; m_cnt = 0; end
            m_mode = (m_mode + 1) % 3;
         end else if (m_mode == 0 && tk) begin
            m_t = m_t + 1;
            if (m_t == 43200) begin
               m_t = 0;
               m_day = m_pm;
               m_pm = ~m_pm;
            end
         end else if (m_mode == 1 && inc) begin
            if (hh == 11) m_pm = ~m_pm;
            m_t = ((hh + 1) % 12) * 3600 + mm * 60 + ss;
         end else if (m_mode == 2 && inc) begin
            m_t = hh * 3600 + ((mm + 1) % 60) * 60 + ss;
         end
      end
      started = 1'b1;
   end

   function automatic logic [27:0] pack(int hr_disp, int mn, int sc, logic p, int st, logic d);
      return {4'(hr_disp / 10), 4'(hr_disp % 10), 4'(mn / 10), 4'(mn % 10),
              4'(sc / 10), 4'(sc % 10), p, 2'(st), d};
   endfunction

   function automatic logic [27:0] model_vec();
      int hh;
      hh = m_t / 3600;
      return pack((hh == 0) ? 12 : hh, (m_t / 60) % 60, m_t % 60, m_pm, m_mode, m_day);
   endfunction

   wire [27:0] dut_vec = {hr_t, hr_o, min_t, min_o, sec_t, sec_o, pm, state, day};

   always @(negedge clk) begin
      if (day === 1'b1) day_seen++;
      if (started) begin
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL model_cmp t=%0t dut=%h expected=%h", $time, dut_vec, model_vec());
         end
      end
   end

   task automatic chk(input string name, input logic [27:0] exp);
      checks++;
      if (dut_vec !== exp) begin
         errors++;
         $display("FAIL %s dut=%h expected=%h", name, dut_vec, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic pulse(input logic m, input logic i, input int n);
      repeat (n) begin
         @(negedge clk); mode = m; inc = i;
         @(negedge clk); mode = 1'b0; inc = 1'b0;
      end
   endtask

   task automatic run(input int n);
      @(negedge clk); en = 1'b0;
      repeat (n - 1) @(negedge clk);
      #1 ;
      @(negedge clk); en = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic set_time(input int hr_incs, input int min_incs);
      pulse(1'b1, 1'b0, 1);
      pulse(1'b0, 1'b1, hr_incs);
      pulse(1'b1, 1'b0, 1);
      pulse(1'b0, 1'b1, min_incs);
      pulse(1'b1, 1'b0, 1);
   endtask

   initial begin
      int d0;
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; inc = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("reset", pack(12, 0, 0, 1'b0, 0, 1'b0));
      rst_n = 1'b1;
      repeat (120) @(negedge clk);
      chk("count_120", pack(12, 1, 0, 1'b0, 0, 1'b0));
      en = 1'b1;
      repeat (10) @(negedge clk);
      chk("hold_10", pack(12, 1, 0, 1'b0, 0, 1'b0));
      en = 1'b0;
      @(negedge clk);
      chk("presc_frozen_1", pack(12, 1, 0, 1'b0, 0, 1'b0));
      @(negedge clk);
      chk("presc_frozen_2", pack(12, 1, 1, 1'b0, 0, 1'b0));
      en = 1'b1;

      do_reset();
      set_time(11, 59);
      chk("noon_set", pack(11, 59, 0, 1'b0, 0, 1'b0));
      d0 = day_seen;
      @(negedge clk); en = 1'b0;
      repeat (120) @(negedge clk);
      en = 1'b1;
      chk("noon", pack(12, 0, 0, 1'b1, 0, 1'b0));
      chk_int("noon_no_day", day_seen - d0, 0);

      set_time(11, 59);
      chk("midnight_set", pack(11, 59, 0, 1'b1, 0, 1'b0));
      d0 = day_seen;
      @(negedge clk); en = 1'b0;
      repeat (120) @(negedge clk);
      chk("midnight", pack(12, 0, 0, 1'b0, 0, 1'b1));
      en = 1'b1;
      @(negedge clk);
      chk_int("midnight_day_once", day_seen - d0, 1);

      set_time(17, 37);
      @(negedge clk); en = 1'b0;
      repeat (24) @(negedge clk);
      en = 1'b1;
      chk("pm_5_37_12", pack(5, 37, 12, 1'b1, 0, 1'b0));
      rst_n = 1'b0;
      @(negedge clk);
      chk("reset_mid_run", pack(12, 0, 0, 1'b0, 0, 1'b0));
      rst_n = 1'b1;

      pulse(1'b1, 1'b0, 1);
      pulse(1'b0, 1'b1, 11);
      chk("set_hr_11", pack(11, 0, 0, 1'b0, 1, 1'b0));
      pulse(1'b0, 1'b1, 1);
      chk("set_hr_wrap", pack(12, 0, 0, 1'b1, 1, 1'b0));
      pulse(1'b1, 1'b1, 1);
      chk("mode_beats_inc", pack(12, 0, 0, 1'b1, 2, 1'b0));
      pulse(1'b0, 1'b1, 60);
      chk("set_min_wrap", pack(12, 0, 0, 1'b1, 2, 1'b0));
      pulse(1'b1, 1'b0, 1);

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         mode  = ($urandom_range(0, 15) == 0);
         inc   = ($urandom_range(0, 3) == 0);
         en    = ($urandom_range(0, 7) == 0);
         rst_n = ($urandom_range(0, 999) != 0);
      end
      @(negedge clk);
      mode = 1'b0; inc = 1'b0; en = 1'b1; rst_n = 1'b1;
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hour12_clock.md
# hour12_clock

Registered 12-hour time-of-day counter for the digital-clock design. It divides the system clock to a 1 Hz tick and holds seconds, minutes, hour and AM/PM state. It advances hours with mod-12 next-state behaviour (11 wraps to 0) and provides a MODE/INC set-time state machine. Its BCD outputs feed the seven-segment display decoders directly.

## Interface
- DIV, 50000000: CLK cycles per one-second tick; benches override to a small value, minimum 2.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- EN  in  1  active-low count enable; 0 = time runs, 1 = hold. Only honoured in RUN.
- MODE  in  1  single-cycle pulse; advances the set-time state.
- INC  in  1  single-cycle pulse; increments the field selected by the set-time state.
- HR_T, HR_O  out  4 each  hour tens/ones BCD, display range 1..12.
- MIN_T, MIN_O  out  4 each  minute tens/ones BCD, 00..59.
- SEC_T, SEC_O  out  4 each  second tens/ones BCD, 00..59.
- PM  out  1  0 = AM, 1 = PM.
- STATE  out  2  00 RUN, 01 SET_HR, 10 SET_MIN; 11 is never produced.
- DAY  out  1  one-cycle pulse on the 11:59:59 PM to 12:00:00 AM rollover.

## Operation
- **Hour register H:** binary 0..11.
  - Display decode: H=0 shows 1,2; H=1..9 shows 0,H; H=10,11 shows 1,H-10.
  - Next hour is H+1, except 11 goes to 0. PM toggles on every 11-to-0 transition.
- **Minutes and seconds:** stored as BCD digit pairs. Ones digit 9 goes to 0 with tens+1; the pair at 59 goes to 00 and generates a carry.
- **Prescaler:** counts 0..DIV-1 only while STATE=RUN and EN=0; otherwise it holds. The tick is the cycle where prescaler=DIV-1 and it is counting; the prescaler then returns to 0.
- **Tick in RUN:** seconds increment. Seconds carry increments minutes. Minutes carry advances H. If that advance is 11-to-0 with PM=1, then PM goes to 0 and DAY=1 for that cycle.
- **FSM on MODE pulse:**
  - RUN to SET_HR: seconds cleared to 00, prescaler cleared.
  - SET_HR to SET_MIN.
  - SET_MIN to RUN: seconds cleared to 00, prescaler cleared.
- **INC in SET_HR:** H advances mod 12. An 11-to-0 advance toggles PM, with no DAY pulse. Minutes are unchanged.
- **INC in SET_MIN:** minutes advance mod 60, with no carry into H. INC in RUN is ignored.
- **Simultaneous events:**
  - MODE and INC in the same cycle: MODE wins, INC is dropped.
  - EN is ignored outside RUN.
  - RST_N=0 overrides every other input.
- **Reset values** (RST_N sampled low): H=0 (HR_T=1, HR_O=2), MIN=00, SEC=00, PM=0, STATE=00, DAY=0, prescaler=0.

## Timing
- All registers update on the CLK rising edge. BCD outputs are a combinational decode of the registers and are valid one edge after the causing event.
- Tick latency: with EN=0 held from reset release, the first second increment lands on the DIV-th rising edge after RST_N goes high. Subsequent increments follow every DIV edges.
- A full carry chain (seconds, minutes, hour, PM, DAY) resolves on the single tick edge; there are no intermediate states.
- DAY is high for exactly one CLK cycle, coincident with the 12:00:00 AM outputs.
- Reset mid-operation: the next edge with RST_N=0 forces reset values regardless of STATE or prescaler phase.
- Input pulses are sampled every edge. A pulse held for N cycles counts as N events; debouncing is done upstream.

## Test plan
- Reset: RST_N=0 for 2 cycles, then 1 → HR 1,2, MIN 0,0, SEC 0,0, PM=0, STATE=00, DAY=0.
- Counting, DIV=2: EN=0 for 120 cycles → 12:01:00 AM. Then EN=1 for 10 cycles → outputs unchanged and prescaler frozen.
- Noon rollover, DIV=2:
  - Set: MODE; INC×11 (HR 1,1); MODE; INC×59 (MIN 5,9); MODE → STATE=00, SEC 00.
  - EN=0 for 120 cycles → 12:00:00 PM, PM=1, DAY never asserted.
- Midnight rollover: repeat the noon sequence from the 12:00:00 PM state → 12:00:00 AM, PM=0, DAY=1 for exactly one cycle.
- Set-mode edges:
  - SET_HR at H=11, INC → HR 1,2 and PM toggles.
  - SET_MIN at 59, INC → MIN 00 and hour unchanged.
  - MODE+INC in the same cycle in SET_HR → STATE=10, H unchanged.
- Reset mid-run: at 5:37:12 PM, RST_N=0 for one cycle → 12:00:00 AM, STATE=00 on that edge.
